// File: rtl/key_unlock_if.sv
// Key-in / payload-out handshake bundle for key_unlock_ctrl.
// slave is the controller side; master is the host/consumer side.
interface key_unlock_if;
    logic [31:0] key;
    logic        key_valid;
    logic        key_ready;
    logic [31:0] data;
    logic        data_valid;
    logic        data_ready;

    modport master (
        output key, key_valid, data_ready,
        input  key_ready, data, data_valid
    );

    modport slave (
        input  key, key_valid, data_ready,
        output key_ready, data, data_valid
    );
endinterface

// File: rtl/key_unlock_ctrl.sv
// Stateful, rate-limited unlock: matches a four-word key sequence, locks out
// after repeated failures, and streams a four-word payload on success.
module key_unlock_ctrl #(
    parameter logic [31:0] KEY0           = 32'h9DA79FF0,
    parameter logic [31:0] KEY1           = 32'h1337C0DE,
    parameter logic [31:0] KEY2           = 32'hCAFEBABE,
    parameter logic [31:0] KEY3           = 32'h0BADF00D,
    parameter logic [31:0] PAY0           = 32'h00464C45,
    parameter logic [31:0] PAY1           = 32'h00010101,
    parameter logic [31:0] PAY2           = 32'h00000000,
    parameter logic [31:0] PAY3           = 32'h00000000,
    parameter int          MAX_FAILS      = 3,
    parameter int          LOCKOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    key_unlock_if.slave  bus,
    output logic [1:0]   fail_count,
    output logic         locked_out,
    output logic         unlocked
);
    localparam logic [2:0] MAX_F    = 3'(MAX_FAILS);
    localparam logic [7:0] LOCK_LEN = 8'(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {COLLECT, EMIT, LOCKOUT, DONE} state_t;

    logic [3:0][31:0] key_tbl;
    logic [3:0][31:0] pay_tbl;
    assign key_tbl = {KEY3, KEY2, KEY1, KEY0};
    assign pay_tbl = {PAY3, PAY2, PAY1, PAY0};

    state_t      state_reg;
    logic [1:0]  stage_reg;
    logic [1:0]  idx_reg;
    logic [1:0]  fail_reg;
    logic [7:0]  cnt_reg;
    logic        key_ready_reg;
    logic        data_valid_reg;
    logic [31:0] data_reg;
    logic        locked_reg;
    logic        unlocked_reg;
    logic        accept;

    assign accept = bus.key_valid & key_ready_reg & (state_reg == COLLECT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= COLLECT;
            stage_reg      <= 2'd0;
            idx_reg        <= 2'd0;
            fail_reg       <= 2'd0;
            cnt_reg        <= 8'd0;
            key_ready_reg  <= 1'b0;
            data_valid_reg <= 1'b0;
            data_reg       <= 32'd0;
            locked_reg     <= 1'b0;
            unlocked_reg   <= 1'b0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    key_ready_reg <= 1'b1;
                    if (accept) begin
                        if (bus.key == key_tbl[stage_reg]) begin
                            if (stage_reg == 2'd3) begin
                                state_reg      <= EMIT;
                                stage_reg      <= 2'd0;
                                idx_reg        <= 2'd0;
                                key_ready_reg  <= 1'b0;
                                data_valid_reg <= 1'b1;
                                data_reg       <= pay_tbl[0];
                            end else begin
                                stage_reg <= stage_reg + 2'd1;
                            end
                        end else begin
                            stage_reg <= 2'd0;
                            // Saturating count; hitting the limit starts the lockout.
                            if ({1'b0, fail_reg} + 3'd1 >= MAX_F) begin
                                fail_reg      <= MAX_F[1:0];
                                state_reg     <= LOCKOUT;
                                cnt_reg       <= LOCK_LEN;
                                key_ready_reg <= 1'b0;
                                locked_reg    <= 1'b1;
                            end else begin
                                fail_reg <= fail_reg + 2'd1;
                            end
                        end
                    end
                end
                EMIT: begin
                    if (bus.data_ready) begin
                        if (idx_reg == 2'd3) begin
                            state_reg      <= DONE;
                            data_valid_reg <= 1'b0;
                            data_reg       <= 32'd0;
                            unlocked_reg   <= 1'b1;
                        end else begin
                            idx_reg  <= idx_reg + 2'd1;
                            data_reg <= pay_tbl[idx_reg + 2'd1];
                        end
                    end
                end
                LOCKOUT: begin
                    cnt_reg <= cnt_reg - 8'd1;
                    // Leave on the edge the counter hits zero so key_ready rises right after.
                    if (cnt_reg == 8'd1) begin
                        state_reg     <= COLLECT;
                        locked_reg    <= 1'b0;
                        key_ready_reg <= 1'b1;
                        fail_reg      <= 2'd0;
                        stage_reg     <= 2'd0;
                    end
                end
                default: begin
                    key_ready_reg  <= 1'b0;
                    data_valid_reg <= 1'b0;
                    data_reg       <= 32'd0;
                end
            endcase
        end
    end

    assign bus.key_ready  = key_ready_reg;
    assign bus.data_valid = data_valid_reg;
    assign bus.data       = data_reg;
    assign fail_count     = fail_reg;
    assign locked_out     = locked_reg;
    assign unlocked       = unlocked_reg;
endmodule

// File: tb/tb_key_unlock_ctrl.sv
// Randomized and directed bench for key_unlock_ctrl against a behavioural model.
module tb_key_unlock_ctrl;
    localparam int MAX_FAILS = 3;
    localparam int LOCK_CYC  = 16;

    logic [31:0] KEYS [4] = '{32'h9DA79FF0, 32'h1337C0DE, 32'hCAFEBABE, 32'h0BADF00D};
    logic [31:0] PAYS [4] = '{32'h00464C45, 32'h00010101, 32'h00000000, 32'h00000000};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] fail_count;
    logic       locked_out;
    logic       unlocked;

    key_unlock_if ki ();

    key_unlock_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (ki.slave),
        .fail_count (fail_count),
        .locked_out (locked_out),
        .unlocked   (unlocked)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: counts of matched words, failures, remaining lockout
    // cycles and payload words delivered, updated from what each edge samples.
    bit checking = 0;
    bit m_fresh  = 1;
    int m_match  = 0;
    int m_fails  = 0;
    int m_lock   = 0;
    int m_sent   = 0;
    bit m_emit   = 0;
    bit m_done   = 0;

    function automatic bit exp_ready();
        return !m_fresh && m_lock == 0 && !m_emit && !m_done;
    endfunction

    always @(posedge clk) begin
        bit rdy;
        if (!rst_n) begin
            checking = 1;
            m_fresh = 1; m_match = 0; m_fails = 0; m_lock = 0;
            m_sent = 0; m_emit = 0; m_done = 0;
        end else if (checking) begin
            rdy = exp_ready();
            m_fresh = 0;
            if (m_lock > 0) begin
                m_lock--;
                if (m_lock == 0) begin
                    m_fails = 0;
                    m_match = 0;
                end
            end else if (m_emit) begin
                if (ki.data_ready) begin
                    m_sent++;
                    if (m_sent == 4) begin
                        m_emit = 0;
                        m_done = 1;
                        m_sent = 0;
                    end
                end
            end else if (rdy && ki.key_valid) begin
                if (ki.key == KEYS[m_match]) begin
                    m_match++;
                    if (m_match == 4) begin
                        m_match = 0;
                        m_emit  = 1;
                        m_sent  = 0;
                    end
                end else begin
                    m_match = 0;
                    if (m_fails < MAX_FAILS) m_fails++;
                    if (m_fails == MAX_FAILS) m_lock = LOCK_CYC;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            check("key_ready",  {31'd0, ki.key_ready},  {31'd0, exp_ready()});
            check("data_valid", {31'd0, ki.data_valid}, {31'd0, m_emit});
            check("data",       ki.data,                m_emit ? PAYS[m_sent] : 32'd0);
            check("fail_count", {30'd0, fail_count},    32'(m_fails));
            check("locked_out", {31'd0, locked_out},    {31'd0, m_lock > 0});
            check("unlocked",   {31'd0, unlocked},      {31'd0, m_done});
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        ki.key_valid  = 1'b0;
        ki.data_ready = 1'b0;
        @(negedge clk);
        check("rst_key_ready",  {31'd0, ki.key_ready},  32'd0);
        check("rst_data_valid", {31'd0, ki.data_valid}, 32'd0);
        check("rst_unlocked",   {31'd0, unlocked},      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_key_ready", {31'd0, ki.key_ready}, 32'd1);
    endtask

    task automatic send(input logic [31:0] w);
        ki.key       = w;
        ki.key_valid = 1'b1;
        @(negedge clk);
        ki.key_valid = 1'b0;
    endtask

    task automatic send_keys();
        for (int i = 0; i < 4; i++) send(KEYS[i]);
    endtask

    initial begin
        int k;
        ki.key = 32'd0;
        ki.key_valid = 1'b0;
        ki.data_ready = 1'b0;

        // Back-to-back unlock, payload on four consecutive cycles
        do_reset();
        send_keys();
        ki.data_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("pay_word", ki.data, PAYS[i]);
            @(negedge clk);
        end
        check("unlocked_after", {31'd0, unlocked}, 32'd1);
        check("ready_done", {31'd0, ki.key_ready}, 32'd0);

        // Partial sequence then wrong word, then a good sequence
        do_reset();
        send(KEYS[0]); send(KEYS[1]); send(32'hDEADBEEF);
        check("one_fail", {30'd0, fail_count}, 32'd1);
        send_keys();
        ki.data_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("unlock_after_fail", {31'd0, unlocked}, 32'd1);

        // Lockout length, keys offered during lockout ignored
        do_reset();
        send(32'h1); send(32'h2); send(32'h3);
        ki.key = KEYS[0];
        ki.key_valid = 1'b1;
        k = 0;
        while (locked_out && k < 40) begin
            k++;
            @(negedge clk);
        end
        ki.key_valid = 1'b0;
        check("lockout_len", 32'(k), 32'd16);
        check("lockout_exit_ready", {31'd0, ki.key_ready}, 32'd1);
        check("lockout_exit_fails", {30'd0, fail_count}, 32'd0);

        // data_ready toggling: each word held, 8 cycles from first word to DONE
        do_reset();
        send_keys();
        k = 0;
        while (!unlocked && k < 30) begin
            ki.data_ready = (k % 2 == 0);
            @(negedge clk);
            k++;
        end
        check("toggle_cycles_to_done", 32'(k + 1), 32'd8);

        // Reset during PAY1 with simultaneous handshake
        do_reset();
        send_keys();
        ki.data_ready = 1'b1;
        @(negedge clk);
        check("mid_emit_pay1", ki.data, PAYS[1]);
        rst_n = 1'b0;
        @(negedge clk);
        check("emit_rst_valid", {31'd0, ki.data_valid}, 32'd0);
        check("emit_rst_data", ki.data, 32'd0);
        rst_n = 1'b1;
        ki.data_ready = 1'b0;
        @(negedge clk);
        send_keys();
        ki.data_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("unlock_after_emit_rst", {31'd0, unlocked}, 32'd1);

        // Reset with five lockout cycles remaining
        do_reset();
        send(32'h1); send(32'h2); send(32'h3);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("lock_rst_locked", {31'd0, locked_out}, 32'd0);
        check("lock_rst_fails", {30'd0, fail_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        send_keys();
        ki.data_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("unlock_after_lock_rst", {31'd0, unlocked}, 32'd1);

        // Two failures then success: count holds through EMIT
        do_reset();
        send(32'h5); send(32'h6);
        send_keys();
        ki.data_ready = 1'b0;
        check("fails_in_emit", {30'd0, fail_count}, 32'd2);
        check("no_lock_in_emit", {31'd0, locked_out}, 32'd0);
        ki.data_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("unlock_two_fails", {31'd0, unlocked}, 32'd1);

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            if (unlocked) rst_n = ($urandom_range(0, 4) != 0);
            else          rst_n = ($urandom_range(0, 299) != 0);
            ki.key_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 6)      ki.key = KEYS[m_match];
            else if (r < 8) ki.key = KEYS[$urandom_range(0, 3)];
            else            ki.key = $urandom;
            ki.data_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/key_unlock_ctrl.md
# key_unlock_ctrl

Sequencing controller for the key-check datapath: accepts a stream of 32-bit key words over a valid/ready handshake and compares them in order against a fixed four-word unlock sequence. Tracks failed attempts and enforces a timed lockout after too many failures. On a complete match it streams a four-word payload out over a second valid/ready handshake, then latches an unlocked status. It sits between the host-facing key input and the payload consumer and replaces free-running single-word comparison with a stateful, rate-limited unlock.

## Interface
- KEY0, 32'h9DA79FF0, expected key word for stage 0
- KEY1, 32'h1337C0DE, expected key word for stage 1
- KEY2, 32'hCAFEBABE, expected key word for stage 2
- KEY3, 32'h0BADF00D, expected key word for stage 3
- PAY0..PAY3, 32'h00464C45 / 32'h00010101 / 32'h00000000 / 32'h00000000, payload words emitted in order
- MAX_FAILS, 3, failed attempts that trigger lockout (1..3)
- LOCKOUT_CYCLES, 16, lockout duration in clocks (>=1, <=255)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- key  in  32  candidate key word
- key_valid  in  1  key word present
- key_ready  out  1  controller accepts key this cycle
- data  out  32  payload word; 0 whenever data_valid=0
- data_valid  out  1  payload word present
- data_ready  in  1  consumer accepts payload word
- fail_count  out  2  failed attempts since last lockout/reset
- locked_out  out  1  high during lockout
- unlocked  out  1  sticky; high after full payload delivered

## Operation
- States: COLLECT, EMIT, LOCKOUT, DONE. Reset state COLLECT, stage=0.
- Reset values: key_ready=0 during the reset cycle, then 1 (COLLECT); data=0, data_valid=0, fail_count=0, locked_out=0, unlocked=0.
- COLLECT: key_ready=1. Accept = key_valid & key_ready.
  - Accepted word == KEY[stage]: if stage<3, stage++. If stage==3, go to EMIT with word index 0.
  - Mismatch: stage=0, fail_count++. If the new count == MAX_FAILS, go to LOCKOUT and load the counter with LOCKOUT_CYCLES.
  - key_valid with no match/mismatch outside COLLECT is ignored; words are not buffered.
- EMIT: key_ready=0. data_valid=1, data=PAY[idx]. On data_valid & data_ready: idx++. After idx 3 is accepted, go to DONE. data/data_valid hold stable while data_ready=0.
- LOCKOUT: key_ready=0, locked_out=1. The counter decrements each cycle. When it reaches 0, clear fail_count and stage, then return to COLLECT.
- DONE: unlocked=1, key_ready=0, data_valid=0, data=0. Terminal until rst_n=0.
- Mismatch is evaluated per word; a partial correct sequence followed by a wrong word counts as one failure.
- fail_count saturates; it is never incremented beyond MAX_FAILS.

## Timing
- Compare latency: the state, stage and fail_count update on the clock edge that accepts the word. Outputs reflect the new state the following cycle.
- Last correct word accepted at edge N: data_valid=1 with PAY0 from cycle N+1. Fastest full payload is 4 cycles with data_ready held high. unlocked=1 the cycle after PAY3 is accepted.
- Failing word accepted at edge N with count reaching MAX_FAILS: locked_out=1 and key_ready=0 for exactly LOCKOUT_CYCLES cycles (N+1 .. N+LOCKOUT_CYCLES). key_ready=1 and fail_count=0 at N+LOCKOUT_CYCLES+1.
- Back-to-back keys: one word per cycle is accepted in COLLECT, with no bubble after a match or a non-terminal mismatch.
- key_valid high at the edge COLLECT exits: the word is consumed (key_ready was 1). key_valid in the first cycle of EMIT/LOCKOUT is not accepted.
- Reset mid-EMIT or mid-LOCKOUT: on the next edge with rst_n=0 all outputs take their reset values. Any partial payload is abandoned and the lockout is cancelled.
- rst_n=0 takes priority over any simultaneous handshake.

## Test plan
- Reset, then send KEY0..KEY3 back-to-back with data_ready=1 -> data = 00464C45, 00010101, 0, 0 on 4 consecutive cycles; unlocked=1 afterwards; key_ready=0.
- Send KEY0, KEY1, 0xDEADBEEF -> fail_count=1, stage reset. Then send KEY0..KEY3 -> unlock succeeds.
- Three wrong words -> locked_out=1 for exactly 16 cycles with key_ready=0, keys offered during lockout ignored; then fail_count=0 and key_ready=1.
- Full match with data_ready toggling 1/0 each cycle -> each payload word held while data_ready=0, no word skipped or duplicated; 8 cycles to DONE.
- Assert rst_n=0 at PAY1 and at lockout count 5 -> next cycle all outputs are at reset values, and a fresh KEY0..KEY3 unlocks normally.
- Two failures, then a correct sequence -> no lockout, unlock succeeds, fail_count stays 2 through EMIT.
